// File: rtl/square_accum_ms.sv
// Multi-channel square-and-accumulate engine: squares tagged samples and emits per-channel window mean-square.
// Optional macro SQACC_ROUND_EN selects round-half-up on the window mean (default: truncate).
module square_accum_ms #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_chan,
  output logic [2*DATA_W-2:0]      out_ms,
  output logic                     dropped
);

  localparam int unsigned SQ_W  = 2 * DATA_W - 1;
  localparam int unsigned P_W   = 2 * DATA_W;
  localparam int unsigned ACC_W = SQ_W + WIN_LOG2;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic                     r_s1_valid;
  logic [CH_W-1:0]          r_s1_chan;
  logic signed [DATA_W-1:0] r_s1_data;

  logic                     r_s2_valid;
  logic [CH_W-1:0]          r_s2_chan;
  logic [SQ_W-1:0]          r_s2_sq;

  logic [ACC_W-1:0]         r_acc [CHANNELS];
  logic [WIN_LOG2-1:0]      r_cnt [CHANNELS];

  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_chan;
  logic [SQ_W-1:0]          r_out_ms;
  logic                     r_dropped;

  logic                     w_chan_ok;
  logic signed [P_W-1:0]    w_ext;
  logic signed [P_W-1:0]    w_prod;
  logic [ACC_W-1:0]         w_acc_cur;
  logic [WIN_LOG2-1:0]      w_cnt_cur;
  logic                     w_last;
  logic [SUM_W-1:0]         w_sum;
  logic [SUM_W-1:0]         w_rsum;
  logic [SUM_W-1:0]         w_shift;
  logic [SQ_W-1:0]          w_mean;
  logic                     w_done;
  logic                     w_slot_free;

  assign w_chan_ok = ({1'b0, in_chan} < (CH_W + 1)'(CHANNELS));

  // Sign-extend before multiplying so the full-width product is exact.
  assign w_ext  = P_W'(r_s1_data);
  assign w_prod = w_ext * w_ext;

  assign w_acc_cur = r_acc[r_s2_chan];
  assign w_cnt_cur = r_cnt[r_s2_chan];
  assign w_last    = (w_cnt_cur == '1);
  assign w_sum     = SUM_W'(w_acc_cur) + SUM_W'(r_s2_sq);

`ifdef SQACC_ROUND_EN
  assign w_rsum = w_sum + SUM_W'(2 ** (WIN_LOG2 - 1));
`else
  assign w_rsum = w_sum;
`endif

  assign w_shift     = w_rsum >> WIN_LOG2;
  assign w_mean      = SQ_W'(w_shift);
  assign w_done      = r_s2_valid && w_last;
  assign w_slot_free = !r_out_valid || out_ready;

  // S1/S2: input capture and squaring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_chan  <= '0;
      r_s2_sq    <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_chan  <= '0;
      r_s2_sq    <= '0;
    end else begin
      r_s1_valid <= in_valid && w_chan_ok;
      r_s1_chan  <= in_chan;
      r_s1_data  <= in_data;
      r_s2_valid <= r_s1_valid;
      r_s2_chan  <= r_s1_chan;
      r_s2_sq    <= SQ_W'(w_prod);
    end
  end

  // S3: per-channel accumulate; the window restarts even when its result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (r_s2_valid) begin
      if (w_last) begin
        r_acc[r_s2_chan] <= '0;
        r_cnt[r_s2_chan] <= '0;
      end else begin
        r_acc[r_s2_chan] <= ACC_W'(w_sum);
        r_cnt[r_s2_chan] <= w_cnt_cur + WIN_LOG2'(1);
      end
    end
  end

  // Output register with valid/ready hold and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_ms    <= '0;
      r_dropped   <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_ms    <= '0;
      r_dropped   <= 1'b0;
    end else begin
      if (w_done && w_slot_free) begin
        r_out_valid <= 1'b1;
        r_out_chan  <= r_s2_chan;
        r_out_ms    <= w_mean;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_done && !w_slot_free) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign out_ms    = r_out_ms;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_square_accum_ms.sv
// Scoreboard bench for square_accum_ms: directed windows, expected results queued at issue, monitor pops on handshake.
module tb_square_accum_ms;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned WIN_LOG2 = 2;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned SQ_W     = 2 * DATA_W - 1;

`ifdef SQACC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [SQ_W-1:0] ms;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clear;
  logic                     in_valid;
  logic [CH_W-1:0]          in_chan;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_chan;
  logic [SQ_W-1:0]          out_ms;
  logic                     dropped;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  square_accum_ms #(
    .DATA_W  (DATA_W),
    .CHANNELS(CHANNELS),
    .WIN_LOG2(WIN_LOG2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_chan  (in_chan),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan),
    .out_ms   (out_ms),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs are set just after a rising edge and held through the next one.
  task automatic send(input int ch, input int d);
    in_valid = 1'b1;
    in_chan  = CH_W'(ch);
    in_data  = DATA_W'(d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input int ch, input longint ms);
    exp_t e;
    e.ch = CH_W'(ch);
    e.ms = SQ_W'(ms);
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", longint'(out_ms), -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_chan", longint'(out_chan), longint'(e.ch));
        chk("out_ms", longint'(out_ms), longint'(e.ms));
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_ms", longint'(out_ms), 0);
    chk("rst_out_chan", longint'(out_chan), 0);
    chk("rst_dropped", longint'(dropped), 0);

    // Basic window and 3-edge latency.
    push(0, 9);
    send(0, 3); send(0, -3); send(0, 3); send(0, -3);
    in_valid = 1'b0;
    chk("lat_edge1", longint'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge2", longint'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge3", longint'(out_valid), 1);
    chk("basic_dropped", longint'(dropped), 0);
    idle(3);

    // Full-scale negative samples, then a small window exercising the rounding choice.
    push(0, 64'd1073741824);
    repeat (4) send(0, -32768);
    push(0, ROUND ? 2 : 1);
    send(0, 1); send(0, 1); send(0, 1); send(0, 2);
    idle(5);

    // Interleaved channels with back-to-back same-channel pairs; completions one cycle apart.
    push(0, ROUND ? 8 : 7);
    push(1, 100);
    send(0, 1); send(0, 2); send(1, 10); send(1, 10);
    send(0, 3); send(1, 10); send(0, 4); send(1, 10);
    idle(5);

    // Backpressure: second completion is dropped, first held stable.
    out_ready = 1'b0;
    push(0, 1);
    for (int i = 0; i < 4; i++) begin
      send(0, 1); send(1, 2);
    end
    idle(4);
    chk("hold_valid", longint'(out_valid), 1);
    chk("hold_chan", longint'(out_chan), 0);
    chk("hold_ms_a", longint'(out_ms), 1);
    chk("hold_dropped", longint'(dropped), 1);
    idle(2);
    chk("hold_ms_b", longint'(out_ms), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_accept_valid", longint'(out_valid), 0);
    chk("dropped_sticky", longint'(dropped), 1);

    // Asynchronous reset in the middle of a partial window.
    send(0, 7); send(0, 7);
    idle(3);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_dropped", longint'(dropped), 0);
    chk("arst_valid", longint'(out_valid), 0);
    push(0, 25);
    repeat (4) send(0, 5);
    idle(5);

    // Out-of-range channel samples are ignored.
    push(0, 36);
    send(0, 6); send(3, 100); send(0, 6); send(3, 100); send(0, 6); send(3, 100); send(0, 6);
    idle(5);

    // Clear while a sample sits in S2: sample lost, counters restart.
    send(1, 3); send(1, 3);
    idle(3);
    send(1, 9);
    idle(1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_valid", longint'(out_valid), 0);
    push(1, 4);
    repeat (4) send(1, 2);
    idle(8);

    chk("scoreboard_empty", longint'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/square_accum_ms.md
Name: square_accum_ms

Overview:
- Parametrised multi-channel square-and-accumulate engine for the RMS detector path; generalises the single-channel fixed 16-bit squarer/adder.
- Accepts time-multiplexed signed samples tagged with a channel index and squares each one.
- Accumulates the squares per channel over a window of 2^WIN_LOG2 samples, then emits the window mean-square with a valid/ready handshake.
- Sits between the sample stream and the square-root/RMS stage.

Parameters:
- DATA_W, 16, signed sample width (4..27).
- CHANNELS, 2, number of independent channels (1..16).
- WIN_LOG2, 10, log2 of window length in samples per channel (1..16).
- CH_W, $clog2(CHANNELS) min 1, channel index width (derived, do not override).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all accumulators, counters, pipeline and output register.
- in_valid  in  1  sample qualifier; no backpressure on input.
- in_chan  in  CH_W  channel of in_data.
- in_data  in  DATA_W  signed two's-complement sample.
- out_valid  out  1  mean-square result pending.
- out_ready  in  1  consumer accepts result when out_valid&&out_ready.
- out_chan  out  CH_W  channel of result.
- out_ms  out  2*DATA_W-1  unsigned window mean-square.
- dropped  out  1  sticky: a completed window was lost because the output register was occupied.

Behaviour:
- Reset (rst high, async) sets all outputs to 0 and all per-channel accumulators/counters and pipeline valids to 0. clear has the same effect synchronously; clear has priority over every other event in that cycle.
- Pipeline stages:
  - S1: register in_valid, in_chan and in_data. in_valid with in_chan>=CHANNELS is discarded (S1 valid=0).
  - S2: register sq = in_data*in_data, unsigned, 2*DATA_W-1 bits. Max value is 2^(2*DATA_W-2), from -2^(DATA_W-1).
  - S3: per-channel accumulator acc[c] (ACC_W = 2*DATA_W-1+WIN_LOG2 bits) and sample counter cnt[c] (WIN_LOG2 bits).
- S3 update on a valid sample for channel c:
  - If cnt[c] != 2^WIN_LOG2-1: acc[c] += sq; cnt[c] += 1.
  - Else (window complete): result = (acc[c]+sq) >> WIN_LOG2; acc[c] <= 0; cnt[c] <= 0 (wraps).
- Accumulator read/modify/write happens in S3 only. Back-to-back samples on the same channel need no forwarding and must sum exactly. Accumulator cannot overflow by construction.
- Output register:
  - A window completion loads out_chan/out_ms and sets out_valid on the same edge that updates acc.
  - Latency: 3 clk edges from the edge sampling the window's last in_valid to out_valid=1.
- Handshake:
  - out_valid holds, with out_chan/out_ms stable, until out_valid&&out_ready.
  - If completion coincides with the acceptance edge, the new result loads and out_valid stays 1 (no bubble).
  - If completion occurs while out_valid=1 and out_ready=0, the new result is discarded and dropped is set. The old result is kept, and the channel's accumulator still restarts.
  - dropped clears only on rst or clear.
- Independence: each channel's window is independent; interleaving order is arbitrary.

Optional Feature:
- Macro: SQACC_ROUND_EN.
- Defined: mean = (acc+sq + 2^(WIN_LOG2-1)) >> WIN_LOG2, i.e. round-half-up. The intermediate is one bit wider, and the result still fits 2*DATA_W-1 bits.
- Undefined: truncating shift as above.

Test Plan:
- DATA_W=16, CHANNELS=1, WIN_LOG2=2; samples 3,-3,3,-3 consecutive -> out_valid 3 edges after 4th sample, out_ms=9, out_chan=0, dropped=0.
- Same config; four samples of -32768 -> out_ms=1073741824 (2^30), no overflow; follow with 1,1,1,2 -> out_ms=1 truncated (7>>2), or 2 with SQACC_ROUND_EN.
- CHANNELS=2; interleave ch0 {1,2,3,4} and ch1 {10,10,10,10}, including back-to-back same-channel pairs -> ch0 out_ms=7 (30>>2), ch1 out_ms=100, each emitted in completion order.
- out_ready held 0 while both channels complete -> first result held stable, dropped=1; raise out_ready -> one transfer, out_valid=0 next cycle.
- Assert rst asynchronously mid-window after 2 samples, then feed 4 samples of 5 -> out_ms=25, no residual from pre-reset samples.
- in_chan=3 with CHANNELS=2 interleaved among valid samples -> ignored, results unchanged. Pulse clear with a sample in S2 -> sample lost, counters restart at 0.
